switch_box_cfg_pipe: RTL and testbench
======================================

Name: switch_box_cfg_pipe

Overview:
Parametrised successor to the fixed 4-track, 1-bit switch box. It routes NUM_TRACKS tracks of WIDTH bits on each of 4 sides, plus NUM_PE_OUT PE outputs, to every output track.
- Configuration is double-buffered: addressed 32-bit writes fill a shadow store, and config_commit atomically activates it.
- Each output can be combinational or registered, with a stall-controlled pipeline register.
- It sits between tile PE and neighbouring tiles' switch boxes in the CGRA fabric.

Parameters:
NUM_TRACKS, 4, tracks per side (>=2)
WIDTH, 1, bits per track
NUM_PE_OUT, 1, PE outputs selectable by every output track (>=1)
CFG_ADDR_W, 8, config word address width

Ports:
clk  in  1  clock; all state on rising edge
reset  in  1  asynchronous, active-high reset
in_wire  in  4*NUM_TRACKS*WIDTH  input tracks; lane (s*NUM_TRACKS+t) at bits [lane*WIDTH +: WIDTH], side s in 0..3
out_wire  out  4*NUM_TRACKS*WIDTH  output tracks, same lane packing
pe_output  in  NUM_PE_OUT*WIDTH  PE outputs; p at [p*WIDTH +: WIDTH]
config_addr  in  CFG_ADDR_W  config word address
config_data  in  32  config write data
config_en  in  1  write config_data to shadow word config_addr
config_rd  in  1  read request for config_addr (active word)
config_rdata  out  32  read data, valid 1 cycle after config_rd
config_commit  in  1  copy shadow to active
stall  in  1  holds all registered outputs

Behaviour:
- Encoding
  - SEL_W = clog2(3+NUM_PE_OUT).
  - Per-output field FW = SEL_W+1 bits: [SEL_W-1:0] = sel, [SEL_W] = reg_en.
  - Field index f = s*NUM_TRACKS+t, located at flat bits [f*FW +: FW].
  - NUM_WORDS = ceil(4*NUM_TRACKS*FW/32). Word k is flat bits [32k+31:32k]; bits beyond 4*NUM_TRACKS*FW are unimplemented and read 0.
- Source mapping for out (s,t)
  - sel k in 0..2: source side src = (s+k+1) mod 4, track (t+src+NUM_TRACKS-1) mod NUM_TRACKS.
  - sel 3+p: pe_output p.
  - sel >= 3+NUM_PE_OUT: output drives 0.
- Output path
  - reg_en=0: out_wire lane = mux result, combinational, 0-cycle latency.
  - reg_en=1: out_wire lane = pipeline register, 1-cycle latency. The register loads the mux result every cycle while stall=0 and holds while stall=1.
  - The register always tracks the mux result (subject to stall) regardless of reg_en, so toggling reg_en never exposes stale data older than one cycle.
- Config write: config_en=1 and config_addr<NUM_WORDS writes the shadow word (implemented bits only). config_addr>=NUM_WORDS is ignored.
- Commit: config_commit=1 copies the pre-edge shadow to active. A write in the same cycle lands in shadow only and is not committed until the next commit. Routing changes take effect in the cycle after the commit edge.
- Readback: config_rd=1 registers the active word at config_addr into config_rdata. Out-of-range address yields 0. config_rdata holds its value when config_rd=0. A read in a commit cycle returns the pre-commit active value.
- Reset (async): shadow, active, all pipeline registers and config_rdata clear to 0.
  - All-zero config means every output is combinational with sel 0, i.e. source side s+1.
  - Reset asserted during a write or commit aborts it; no partial state survives.

Decomposition:
- Package sb_pkg: sel encoding constants (SEL_SIDE0..2, SEL_PE_BASE), functions clog2, sb_num_words(NUM_TRACKS,NUM_PE_OUT), sb_src_track(s,k,t,NUM_TRACKS).
- Sub-module sb_track_mux: one output lane. It contains the (3+NUM_PE_OUT)-way WIDTH mux, the stall-enabled register and the reg_en bypass. Generated 4*NUM_TRACKS times.
- Config shadow/active store and readback stay in the top module.

Test Plan:
- Defaults (FW=3, NUM_WORDS=2): assert reset with random inputs -> out_wire lane(0,t) = in_wire lane(1,t); config_rdata=0.
- Write addr0=0x00000001 without commit -> routing unchanged. Pulse commit -> next cycle out(0,0)=in(2,1).
- Write addr0=0x00007000 (field4 sel=3, reg_en=1), commit, drive pe_output 0->1 -> out(1,0) rises 1 cycle later. With stall=1, out(1,0) holds while pe_output toggles.
- Write addr1=0xFFFFABCD, commit, read addr1 -> config_rdata=0x0000ABCD next cycle. Write and read addr2 -> write ignored, rdata=0.
- Write and commit in the same cycle -> active = old shadow. A second commit applies the new word.
- Assert reset mid-stream with registered lanes active -> out_wire immediately 0 on registered lanes, active config 0, rdata 0.

Source files
------------

// File: rtl/sb_pkg.sv
// Shared encoding constants and elaboration-time helpers for the parametrised switch box.
// Every sizing decision in the top derives from these functions.
package sb_pkg;

  localparam int NUM_SIDES   = 4;
  localparam int SEL_SIDE0   = 0;
  localparam int SEL_SIDE1   = 1;
  localparam int SEL_SIDE2   = 2;
  localparam int SEL_PE_BASE = 3;
  localparam int CFG_WORD_W  = 32;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Per-output field: select bits plus one reg_en bit on top.
  function automatic int sb_field_w(input int num_pe_out);
    return clog2(SEL_PE_BASE + num_pe_out) + 1;
  endfunction

  function automatic int sb_num_words(input int num_tracks, input int num_pe_out);
    return (NUM_SIDES * num_tracks * sb_field_w(num_pe_out) + CFG_WORD_W - 1) / CFG_WORD_W;
  endfunction

  function automatic int sb_src_side(input int s, input int k);
    return (s + k + 1) % NUM_SIDES;
  endfunction

  // Track rotation follows the source side so that tracks spread across the box.
  function automatic int sb_src_track(input int s, input int k, input int t, input int num_tracks);
    return (t + sb_src_side(s, k) + num_tracks - 1) % num_tracks;
  endfunction

endpackage

// File: rtl/switch_box_cfg_pipe_if.sv
// Data tracks, PE inputs, stall and configuration bus of the switch box.
// The master side drives routing inputs and config; the slave side is the switch box.
interface switch_box_cfg_pipe_if
  import sb_pkg::*;
#(
  parameter int NUM_TRACKS = 4,
  parameter int WIDTH      = 1,
  parameter int NUM_PE_OUT = 1,
  parameter int CFG_ADDR_W = 8
);

  localparam int LANE_BITS = NUM_SIDES * NUM_TRACKS * WIDTH;

  logic [LANE_BITS-1:0]          in_wire;
  logic [LANE_BITS-1:0]          out_wire;
  logic [NUM_PE_OUT*WIDTH-1:0]   pe_output;
  logic [CFG_ADDR_W-1:0]         config_addr;
  logic [CFG_WORD_W-1:0]         config_data;
  logic                          config_en;
  logic                          config_rd;
  logic [CFG_WORD_W-1:0]         config_rdata;
  logic                          config_commit;
  logic                          stall;

  modport master (
    output in_wire,
    output pe_output,
    output config_addr,
    output config_data,
    output config_en,
    output config_rd,
    output config_commit,
    output stall,
    input  out_wire,
    input  config_rdata
  );

  modport slave (
    input  in_wire,
    input  pe_output,
    input  config_addr,
    input  config_data,
    input  config_en,
    input  config_rd,
    input  config_commit,
    input  stall,
    output out_wire,
    output config_rdata
  );

endinterface

// File: rtl/sb_track_mux.sv
// One output lane: source mux, stall-gated pipeline register and reg_en bypass.
// The register follows the mux regardless of reg_en so switching modes never shows old data.
module sb_track_mux
  import sb_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic [NUM_SRC*WIDTH-1:0] src,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     reg_en,
  output logic [WIDTH-1:0]         lane_out
);

  logic [WIDTH-1:0] mux_out;
  logic [WIDTH-1:0] pipe_q;

  // Unused select codes fall through to zero.
  always_comb begin
    mux_out = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel == SEL_W'(i)) mux_out = src[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_q <= '0;
    end else if (!stall) begin
      pipe_q <= mux_out;
    end
  end

  assign lane_out = reg_en ? pipe_q : mux_out;

endmodule

// File: rtl/switch_box_cfg_pipe.sv
// Parametrised CGRA switch box with double-buffered configuration and per-lane pipelining.
// Shadow/active config store and readback live here; lanes are sb_track_mux instances.
module switch_box_cfg_pipe
  import sb_pkg::*;
#(
  parameter int NUM_TRACKS = 4,
  parameter int WIDTH      = 1,
  parameter int NUM_PE_OUT = 1,
  parameter int CFG_ADDR_W = 8
) (
  input logic                  clk,
  input logic                  reset,
  switch_box_cfg_pipe_if.slave bus
);

  localparam int NUM_SRC   = SEL_PE_BASE + NUM_PE_OUT;
  localparam int SEL_W     = clog2(NUM_SRC);
  localparam int FW        = sb_field_w(NUM_PE_OUT);
  localparam int NUM_LANES = NUM_SIDES * NUM_TRACKS;
  localparam int CFG_BITS  = NUM_LANES * FW;
  localparam int NUM_WORDS = sb_num_words(NUM_TRACKS, NUM_PE_OUT);

  logic [CFG_BITS-1:0]        shadow_q;
  logic [CFG_BITS-1:0]        shadow_d;
  logic [CFG_BITS-1:0]        active_q;
  logic [CFG_WORD_W-1:0]      rd_word;
  logic [CFG_WORD_W-1:0]      rdata_q;
  logic [NUM_LANES*WIDTH-1:0] out_all;

  // Only implemented bits exist, so padding above CFG_BITS is never stored and
  // out-of-range addresses simply match no bit.
  always_comb begin
    shadow_d = shadow_q;
    if (bus.config_en) begin
      for (int b = 0; b < CFG_BITS; b++) begin
        if (bus.config_addr == CFG_ADDR_W'(b / CFG_WORD_W))
          shadow_d[b] = bus.config_data[b % CFG_WORD_W];
      end
    end
  end

  always_comb begin
    rd_word = '0;
    for (int b = 0; b < CFG_BITS; b++) begin
      if (bus.config_addr == CFG_ADDR_W'(b / CFG_WORD_W))
        rd_word[b % CFG_WORD_W] = active_q[b];
    end
  end

  // Commit copies the pre-edge shadow, so a same-cycle write waits for the next commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      if (bus.config_commit) active_q <= shadow_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (bus.config_rd) begin
      rdata_q <= rd_word;
    end
  end

  assign bus.config_rdata = rdata_q;

  for (genvar s = 0; s < NUM_SIDES; s++) begin : g_side
    for (genvar t = 0; t < NUM_TRACKS; t++) begin : g_trk
      localparam int LANE = s * NUM_TRACKS + t;

      logic [NUM_SRC*WIDTH-1:0] src;
      logic [FW-1:0]            field;

      for (genvar k = SEL_SIDE0; k <= SEL_SIDE2; k++) begin : g_in
        localparam int SRC_LANE = sb_src_side(s, k) * NUM_TRACKS
                                  + sb_src_track(s, k, t, NUM_TRACKS);
        assign src[k*WIDTH +: WIDTH] = bus.in_wire[SRC_LANE*WIDTH +: WIDTH];
      end

      assign src[SEL_PE_BASE*WIDTH +: NUM_PE_OUT*WIDTH] = bus.pe_output;
      assign field = active_q[LANE*FW +: FW];

      sb_track_mux #(
        .WIDTH   (WIDTH),
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
      ) u_mux (
        .clk      (clk),
        .reset    (reset),
        .stall    (bus.stall),
        .src      (src),
        .sel      (field[SEL_W-1:0]),
        .reg_en   (field[SEL_W]),
        .lane_out (out_all[LANE*WIDTH +: WIDTH])
      );
    end
  end

  assign bus.out_wire = out_all;

endmodule

// File: tb/tb_switch_box_cfg_pipe.sv
// Directed bench for switch_box_cfg_pipe at default parameters, with a word-level
// reference model compared on every falling edge plus literal spot checks.
module tb_switch_box_cfg_pipe;

  localparam int NT        = 4;
  localparam int W         = 1;
  localparam int NPE       = 1;
  localparam int AW        = 8;
  localparam int LANES     = 16;
  localparam int FW        = 3;
  localparam int NWORDS    = 2;
  localparam int IMPL_BITS = 48;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  switch_box_cfg_pipe_if #(.NUM_TRACKS(NT), .WIDTH(W), .NUM_PE_OUT(NPE), .CFG_ADDR_W(AW)) bus ();

  switch_box_cfg_pipe #(.NUM_TRACKS(NT), .WIDTH(W), .NUM_PE_OUT(NPE), .CFG_ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0]      m_shadow [NWORDS];
  logic [31:0]      m_active [NWORDS];
  logic [31:0]      m_rdata;
  logic [LANES-1:0] m_pipe;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_field(input int lane);
    int f;
    f = 0;
    for (int b = 0; b < FW; b++) begin
      int idx;
      idx = lane * FW + b;
      if (m_active[idx / 32][idx % 32] === 1'b1) f += (1 << b);
    end
    return f;
  endfunction

  function automatic logic m_mux(input int lane);
    int s, t, sel, side, trk;
    s   = lane / NT;
    t   = lane % NT;
    sel = m_field(lane) % 4;
    if (sel < 3) begin
      side = (s + sel + 1) % 4;
      trk  = (t + side + NT - 1) % NT;
      return bus.in_wire[side * NT + trk];
    end
    if (sel - 3 < NPE) return bus.pe_output[sel - 3];
    return 1'b0;
  endfunction

  function automatic logic [LANES-1:0] m_mux_all();
    logic [LANES-1:0] v;
    for (int l = 0; l < LANES; l++) v[l] = m_mux(l);
    return v;
  endfunction

  function automatic logic [LANES-1:0] m_out();
    logic [LANES-1:0] v;
    for (int l = 0; l < LANES; l++) v[l] = (m_field(l) >= 4) ? m_pipe[l] : m_mux(l);
    return v;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int w = 0; w < NWORDS; w++) begin
        m_shadow[w] <= '0;
        m_active[w] <= '0;
      end
      m_rdata <= '0;
      m_pipe  <= '0;
    end else begin
      if (!bus.stall) m_pipe <= m_mux_all();
      if (bus.config_rd)
        m_rdata <= (bus.config_addr < NWORDS) ? m_active[bus.config_addr] : 32'h0;
      if (bus.config_commit)
        for (int w = 0; w < NWORDS; w++) m_active[w] <= m_shadow[w];
      if (bus.config_en && bus.config_addr < NWORDS)
        for (int i = 0; i < 32; i++)
          if (32 * int'(bus.config_addr) + i < IMPL_BITS)
            m_shadow[bus.config_addr][i] <= bus.config_data[i];
    end
  end

  always @(negedge clk) begin
    check("out_wire", 64'(bus.out_wire), 64'(m_out()));
    check("config_rdata", 64'(bus.config_rdata), 64'(m_rdata));
  end

  task automatic tick();
    @(negedge clk);
    #1;
    bus.in_wire = 16'($urandom);
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    tick();
    bus.config_en   = 1'b1;
    bus.config_addr = 8'(a);
    bus.config_data = d;
    tick();
    bus.config_en   = 1'b0;
    #1;
  endtask

  task automatic do_commit();
    tick();
    bus.config_commit = 1'b1;
    tick();
    bus.config_commit = 1'b0;
    #1;
  endtask

  task automatic rd(input int a);
    tick();
    bus.config_rd   = 1'b1;
    bus.config_addr = 8'(a);
    tick();
    bus.config_rd   = 1'b0;
    #1;
  endtask

  initial begin
    reset             = 1'b0;
    bus.in_wire       = 16'($urandom);
    bus.pe_output     = 1'b0;
    bus.config_addr   = '0;
    bus.config_data   = '0;
    bus.config_en     = 1'b0;
    bus.config_rd     = 1'b0;
    bus.config_commit = 1'b0;
    bus.stall         = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("rst_side0_from_side1", 64'(bus.out_wire[3:0]), 64'(bus.in_wire[7:4]));
    check("rst_rdata", 64'(bus.config_rdata), 64'h0);
    repeat (2) tick();
    reset = 1'b0;

    wr(0, 32'h0000_0001);
    check("write_no_commit", 64'(bus.out_wire[0]), 64'(bus.in_wire[4]));
    do_commit();
    check("commit_route_in2_1", 64'(bus.out_wire[0]), 64'(bus.in_wire[9]));

    wr(0, 32'h0000_7000);
    do_commit();
    tick(); bus.pe_output = 1'b0;
    tick(); bus.pe_output = 1'b1;
    #1 check("pe_reg_before_edge", 64'(bus.out_wire[4]), 64'h0);
    tick();
    #1 check("pe_reg_after_edge", 64'(bus.out_wire[4]), 64'h1);
    tick(); bus.stall = 1'b1; bus.pe_output = 1'b0;
    tick();
    #1 check("stall_hold", 64'(bus.out_wire[4]), 64'h1);
    bus.pe_output = 1'b1;
    tick(); bus.pe_output = 1'b0;
    tick();
    #1 check("stall_hold_toggle", 64'(bus.out_wire[4]), 64'h1);
    bus.stall = 1'b0;
    tick();
    #1 check("stall_release", 64'(bus.out_wire[4]), 64'h0);

    wr(1, 32'hFFFF_ABCD);
    do_commit();
    rd(1);
    check("readback_word1", 64'(bus.config_rdata), 64'h0000_ABCD);
    wr(2, 32'h1234_5678);
    rd(2);
    check("readback_out_of_range", 64'(bus.config_rdata), 64'h0);

    wr(0, 32'h0000_0005);
    tick();
    bus.config_en     = 1'b1;
    bus.config_addr   = 8'd0;
    bus.config_data   = 32'h0000_0002;
    bus.config_commit = 1'b1;
    bus.config_rd     = 1'b1;
    tick();
    bus.config_en     = 1'b0;
    bus.config_commit = 1'b0;
    bus.config_rd     = 1'b0;
    #1 check("read_in_commit_cycle", 64'(bus.config_rdata), 64'h0000_7000);
    rd(0);
    check("same_cycle_commit_old", 64'(bus.config_rdata), 64'h0000_0005);
    do_commit();
    rd(0);
    check("second_commit_new", 64'(bus.config_rdata), 64'h0000_0002);

    for (int i = 0; i < 40; i++) begin
      tick();
      bus.config_en     = 1'($urandom % 2);
      bus.config_addr   = 8'($urandom % 3);
      bus.config_data   = $urandom;
      bus.config_commit = ($urandom % 3) == 0;
      bus.config_rd     = 1'($urandom % 2);
      bus.stall         = ($urandom % 4) == 0;
      bus.pe_output     = 1'($urandom);
    end
    tick();
    bus.config_en = 1'b0; bus.config_commit = 1'b0; bus.config_rd = 1'b0; bus.stall = 1'b0;

    wr(0, 32'h0000_7E00);
    do_commit();
    tick(); bus.pe_output = 1'b1;
    tick();
    tick();
    #1 check("pre_reset_reg_lane", 64'(bus.out_wire[4:3]), 64'h3);
    tick();
    reset             = 1'b1;
    bus.in_wire       = '0;
    bus.config_en     = 1'b1;
    bus.config_addr   = 8'd0;
    bus.config_data   = 32'h0000_FFFF;
    bus.config_commit = 1'b1;
    #1;
    check("reset_out_zero", 64'(bus.out_wire), 64'h0);
    check("reset_rdata_zero", 64'(bus.config_rdata), 64'h0);
    tick();
    bus.config_en = 1'b0; bus.config_commit = 1'b0;
    tick();
    reset = 1'b0;
    do_commit();
    rd(0);
    check("reset_aborts_write", 64'(bus.config_rdata), 64'h0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
